io_bus_master: RTL and testbench



---
 rtl/io_bus_master_pkg.sv | 29 ++
 rtl/io_bus_master_if.sv | 38 +++
 rtl/io_bus_master_byte_lane.sv | 39 +++
 rtl/io_bus_master.sv | 187 ++++++++++++++++++
 tb/tb_io_bus_master.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_master_pkg.sv
// Shared definitions for the memory-mapped I/O bus initiator: size codes,
// FSM states and defaults. Package name io_bus_pkg.
package io_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int IO_FLAG_BIT            = 31;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_NEXT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Byte count for a size code; 0 marks the illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// CPU request/response port plus byte-wide I/O controller bus of io_bus_master.
// Request: accepted on a CLK edge where REQ_VALID && REQ_READY; REQ_* must be
// stable while REQ_VALID waits. Response: RSP_VALID is a one-cycle pulse with no
// back-pressure. Bus: WE/RREQ held until the cycle RDY pulses, gated off by RDY.
interface io_bus_master_if;

  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] ADDR;
  logic [31:0] BUS_DOUT;
  logic        WE;
  logic        RREQ;
  logic        RDY;
  logic [31:0] BUS_DIN;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_UNSIGNED,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output ADDR, BUS_DOUT, WE, RREQ,
    input  RDY, BUS_DIN
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_UNSIGNED,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  ADDR, BUS_DOUT, WE, RREQ,
    output RDY, BUS_DIN
  );

endinterface

// File: rtl/io_bus_master_byte_lane.sv
// Load reassembly for io_bus_master: four registered byte lanes and a
// combinational sign/zero extension of the assembled value.
module io_byte_lane
  import io_bus_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        cap_en,
  input  logic [1:0]  cap_idx,
  input  logic [7:0]  cap_byte,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [3:0][7:0] lanes;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lanes <= '0;
    end else if (clr) begin
      lanes <= '0;
    end else if (cap_en) begin
      lanes[cap_idx] <= cap_byte;
    end
  end

  always_comb begin
    result = lanes;
    case (size)
      SZ_BYTE: result = uns ? {24'h0, lanes[0]} : {{24{lanes[0][7]}}, lanes[0]};
      SZ_HALF: result = uns ? {16'h0, lanes[1], lanes[0]}
                            : {{16{lanes[1][7]}}, lanes[1], lanes[0]};
      default: result = lanes;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// CPU-side initiator: splits one load/store into little-endian byte transfers on
// the I/O controller bus and returns a single response. Optional RDY timeout
// is compiled in with `define IO_TIMEOUT_EN.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
  input  logic            CLK,
  input  logic            RST,
  io_bus_master_if.master bus,
  output state_t          dbg_state
);

  state_t      state, state_n;
  logic        we_r, we_n;
  logic [31:0] base_r, base_n;
  logic [31:0] wdata_r, wdata_n;
  logic [1:0]  size_r, size_n;
  logic        uns_r, uns_n;
  logic        err_r, err_n;
  logic        flag_r, flag_n;
  logic [1:0]  idx_r, idx_n;
  logic [31:0] addr_r, addr_n;
  logic [7:0]  dout_r, dout_n;

  logic        lane_clr;
  logic        cap_en;
  logic [31:0] lane_result;
  logic [2:0]  req_bytes;
  logic [31:0] last_addr;
  logic [2:0]  cur_bytes;
  logic [1:0]  last_idx;
  logic [1:0]  idx_inc;

`ifdef IO_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_r, cnt_n;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      we_r    <= 1'b0;
      base_r  <= '0;
      wdata_r <= '0;
      size_r  <= SZ_BYTE;
      uns_r   <= 1'b0;
      err_r   <= 1'b0;
      flag_r  <= 1'b0;
      idx_r   <= '0;
      addr_r  <= '0;
      dout_r  <= '0;
`ifdef IO_TIMEOUT_EN
      cnt_r   <= '0;
`endif
    end else begin
      state   <= state_n;
      we_r    <= we_n;
      base_r  <= base_n;
      wdata_r <= wdata_n;
      size_r  <= size_n;
      uns_r   <= uns_n;
      err_r   <= err_n;
      flag_r  <= flag_n;
      idx_r   <= idx_n;
      addr_r  <= addr_n;
      dout_r  <= dout_n;
`ifdef IO_TIMEOUT_EN
      cnt_r   <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    we_n     = we_r;
    base_n   = base_r;
    wdata_n  = wdata_r;
    size_n   = size_r;
    uns_n    = uns_r;
    err_n    = err_r;
    flag_n   = flag_r;
    idx_n    = idx_r;
    addr_n   = addr_r;
    dout_n   = dout_r;
    lane_clr = 1'b0;
    cap_en   = 1'b0;
`ifdef IO_TIMEOUT_EN
    cnt_n    = cnt_r;
`endif
    req_bytes = size_bytes(bus.REQ_SIZE);
    // Last byte address wraps mod 2^32, so a run crossing out of I/O space is caught.
    last_addr = bus.REQ_ADDR + 32'(req_bytes) - 32'd1;
    cur_bytes = size_bytes(size_r);
    last_idx  = 2'(cur_bytes - 3'd1);
    idx_inc   = idx_r + 2'd1;

    case (state)
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          we_n     = bus.REQ_WE;
          base_n   = bus.REQ_ADDR;
          wdata_n  = bus.REQ_WDATA;
          size_n   = bus.REQ_SIZE;
          uns_n    = bus.REQ_UNSIGNED;
          lane_clr = 1'b1;
          if (req_bytes == 3'd0 || !bus.REQ_ADDR[IO_FLAG_BIT] || !last_addr[IO_FLAG_BIT]) begin
            err_n   = 1'b1;
            state_n = ST_RESP;
          end else begin
            err_n   = 1'b0;
            idx_n   = 2'd0;
            flag_n  = 1'b1;
            addr_n  = bus.REQ_ADDR;
            dout_n  = bus.REQ_WDATA[7:0];
`ifdef IO_TIMEOUT_EN
            cnt_n   = '0;
`endif
            state_n = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.RDY) begin
          flag_n  = 1'b0;
          cap_en  = ~we_r;
          state_n = ST_NEXT;
        end
`ifdef IO_TIMEOUT_EN
        else if (cnt_r == TO_LAST) begin
          flag_n  = 1'b0;
          err_n   = 1'b1;
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
`endif
      end
      ST_NEXT: begin
        if (idx_r == last_idx) begin
          state_n = ST_RESP;
        end else begin
          idx_n   = idx_inc;
          addr_n  = base_r + 32'(idx_inc);
          dout_n  = 8'(wdata_r >> {idx_inc, 3'b000});
          flag_n  = 1'b1;
`ifdef IO_TIMEOUT_EN
          cnt_n   = '0;
`endif
          state_n = ST_ISSUE;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  io_byte_lane u_lane (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (lane_clr),
    .cap_en   (cap_en),
    .cap_idx  (idx_r),
    .cap_byte (bus.BUS_DIN[7:0]),
    .size     (size_r),
    .uns      (uns_r),
    .result   (lane_result)
  );

  // The controller leaves its wait state while RDY is high, so the request
  // must drop in that same cycle or it would start a second transfer.
  assign bus.WE        = flag_r &  we_r & ~bus.RDY;
  assign bus.RREQ      = flag_r & ~we_r & ~bus.RDY;
  assign bus.ADDR      = addr_r;
  assign bus.BUS_DOUT  = {24'h0, dout_r};
  assign bus.REQ_READY = (state == ST_IDLE);
  assign bus.RSP_VALID = (state == ST_RESP);
  assign bus.RSP_ERR   = (state == ST_RESP) & err_r;
  assign bus.RSP_RDATA = ((state == ST_RESP) && !err_r && !we_r) ? lane_result : 32'h0;
  assign dbg_state     = state;

  logic unused_ok;
  assign unused_ok = ^{bus.BUS_DIN[31:8], TIMEOUT_CYCLES[0]};

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master with a byte-wide I/O controller model.
// Build with IO_TIMEOUT_EN defined to exercise the RDY timeout path.
module tb_io_bus_master;
  import io_bus_pkg::*;

  localparam int TO = 16;

  logic   CLK = 1'b0;
  logic   RST;
  state_t dbg_state;
  logic   ctl_rdy;
  logic   spur_rdy;
  logic   ctl_en;
  logic   ctl_hold2;
  logic [7:0] rd_mem [0:3];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [40:0] exp_q[$];
  logic [40:0] obs_arr [0:255];
  int obs_n    = 0;
  int obs_rd   = 0;
  int rsp_cnt  = 0;
  int gate_err = 0;

  always #5 CLK = ~CLK;

  io_bus_master_if bus();
  assign bus.RDY = ctl_rdy | spur_rdy;

  io_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // Controller model: sees a request, answers with RDY two cycles later.
  initial begin
    logic       rd;
    logic [1:0] a;
    ctl_rdy     = 1'b0;
    bus.BUS_DIN = 32'h0;
    forever begin
      @(negedge CLK);
      if (ctl_en && (bus.WE || bus.RREQ)) begin
        rd = bus.RREQ;
        a  = bus.ADDR[1:0];
        obs_arr[obs_n] = {bus.WE, bus.ADDR, bus.WE ? bus.BUS_DOUT[7:0] : 8'h00};
        obs_n++;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        ctl_rdy = 1'b1;
        if (rd) bus.BUS_DIN = {24'h0, rd_mem[a]};
        @(posedge CLK);
        if (ctl_hold2) @(posedge CLK);
        #1;
        ctl_rdy = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (bus.RSP_VALID) rsp_cnt++;
    if (bus.RDY && (bus.WE || bus.RREQ)) gate_err++;
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, output int cyc,
                        output logic [31:0] rdata, output logic err, output logic ready_after);
    @(posedge CLK); #1;
    bus.REQ_VALID    = 1'b1;
    bus.REQ_WE       = we;
    bus.REQ_ADDR     = addr;
    bus.REQ_WDATA    = wdata;
    bus.REQ_SIZE     = size;
    bus.REQ_UNSIGNED = uns;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    #2;
    cyc = 1;
    while (!bus.RSP_VALID && cyc < 2000) begin
      @(posedge CLK); #3;
      cyc++;
    end
    rdata = bus.RSP_RDATA;
    err   = bus.RSP_ERR;
    @(posedge CLK); #3;
    ready_after = bus.REQ_READY;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (bus.REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %b exp 1", bus.REQ_READY); end
    tests_run++;
    if ({bus.RSP_VALID, bus.RSP_ERR, bus.WE, bus.RREQ} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_flags got %b exp 0000", {bus.RSP_VALID, bus.RSP_ERR, bus.WE, bus.RREQ});
    end
    tests_run++;
    if (bus.RSP_RDATA !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h exp 0", bus.RSP_RDATA); end
    tests_run++;
    if (bus.ADDR !== 32'h0 || bus.BUS_DOUT !== 32'h0) begin
      tests_failed++; $display("FAIL reset_bus got addr %h dout %h exp 0 0", bus.ADDR, bus.BUS_DOUT);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    #2;
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_word_store();
    int cyc; logic [31:0] rd; logic er, ra;
    logic [40:0] e;
    int base = obs_n;
    obs_rd = obs_n;
    exp_q.push_back({1'b1, 32'h80000008, 8'hD4});
    exp_q.push_back({1'b1, 32'h80000009, 8'hC3});
    exp_q.push_back({1'b1, 32'h8000000A, 8'hB2});
    exp_q.push_back({1'b1, 32'h8000000B, 8'hA1});
    do_req(1'b1, 32'h80000008, 32'hA1B2C3D4, SZ_WORD, 1'b0, cyc, rd, er, ra);
    tests_run++;
    if (cyc !== 17) begin tests_failed++; $display("FAIL word_store_latency got %0d exp 17", cyc); end
    tests_run++;
    if (er !== 1'b0 || rd !== 32'h0) begin tests_failed++; $display("FAIL word_store_rsp got err %b rdata %h exp 0 0", er, rd); end
    tests_run++;
    if (obs_n - base !== 4) begin tests_failed++; $display("FAIL word_store_count got %0d exp 4", obs_n - base); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_arr[obs_rd] !== e) begin tests_failed++; $display("FAIL word_store_txn got %h exp %h", obs_arr[obs_rd], e); end
      obs_rd++;
    end
    tests_run++;
    if (ra !== 1'b1) begin tests_failed++; $display("FAIL word_store_ready got %b exp 1", ra); end
  endtask

  task automatic test_loads();
    int cyc; logic [31:0] rd; logic er, ra;
    logic [40:0] e;
    obs_rd = obs_n;
    rd_mem[0] = 8'h80; rd_mem[1] = 8'hFF;
    exp_q.push_back({1'b0, 32'h80000004, 8'h00});
    exp_q.push_back({1'b0, 32'h80000005, 8'h00});
    do_req(1'b0, 32'h80000004, 32'h0, SZ_HALF, 1'b0, cyc, rd, er, ra);
    tests_run++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin tests_failed++; $display("FAIL half_signed got %h err %b exp ffffff80 0", rd, er); end
    tests_run++;
    if (cyc !== 9) begin tests_failed++; $display("FAIL half_latency got %0d exp 9", cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_arr[obs_rd] !== e) begin tests_failed++; $display("FAIL half_txn got %h exp %h", obs_arr[obs_rd], e); end
      obs_rd++;
    end
    do_req(1'b0, 32'h80000004, 32'h0, SZ_HALF, 1'b1, cyc, rd, er, ra);
    tests_run++;
    if (rd !== 32'h0000FF80) begin tests_failed++; $display("FAIL half_unsigned got %h exp 0000ff80", rd); end
    rd_mem[1] = 8'h9C;
    do_req(1'b0, 32'h80000001, 32'h0, SZ_BYTE, 1'b0, cyc, rd, er, ra);
    tests_run++;
    if (rd !== 32'hFFFFFF9C || cyc !== 5) begin tests_failed++; $display("FAIL byte_signed got %h cyc %0d exp ffffff9c 5", rd, cyc); end
    rd_mem[0] = 8'h11; rd_mem[1] = 8'h22; rd_mem[2] = 8'h33; rd_mem[3] = 8'h84;
    do_req(1'b0, 32'h80000100, 32'h0, SZ_WORD, 1'b0, cyc, rd, er, ra);
    tests_run++;
    if (rd !== 32'h84332211 || cyc !== 17) begin tests_failed++; $display("FAIL word_load got %h cyc %0d exp 84332211 17", rd, cyc); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [0:2];
    logic [1:0]  sizes [0:2];
    int cyc; logic [31:0] rd; logic er, ra;
    int base;
    addrs[0] = 32'h00000010; sizes[0] = SZ_WORD;
    addrs[1] = 32'h80000000; sizes[1] = 2'd3;
    addrs[2] = 32'hFFFFFFFE; sizes[2] = SZ_WORD;
    for (int i = 0; i < 3; i++) begin
      base = obs_n;
      do_req(1'b0, addrs[i], 32'h0, sizes[i], 1'b0, cyc, rd, er, ra);
      tests_run++;
      if (cyc !== 1 || er !== 1'b1 || rd !== 32'h0) begin
        tests_failed++; $display("FAIL err_rsp_%0d got cyc %0d err %b rdata %h exp 1 1 0", i, cyc, er, rd);
      end
      tests_run++;
      if (obs_n !== base || ra !== 1'b1) begin
        tests_failed++; $display("FAIL err_nobus_%0d got txns %0d ready %b exp 0 1", i, obs_n - base, ra);
      end
    end
  endtask

  task automatic test_rdy_robustness();
    int cyc; logic [31:0] rd; logic er, ra;
    logic [40:0] e;
    int base, rsp0, ge0;
    logic bad;
    base = obs_n; obs_rd = obs_n; ge0 = gate_err;
    ctl_hold2 = 1'b1;
    exp_q.push_back({1'b1, 32'h80000020, 8'hEF});
    exp_q.push_back({1'b1, 32'h80000021, 8'hBE});
    do_req(1'b1, 32'h80000020, 32'h0000BEEF, SZ_HALF, 1'b0, cyc, rd, er, ra);
    ctl_hold2 = 1'b0;
    tests_run++;
    if (obs_n - base !== 2 || cyc !== 9) begin tests_failed++; $display("FAIL rdy_hold got txns %0d cyc %0d exp 2 9", obs_n - base, cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_arr[obs_rd] !== e) begin tests_failed++; $display("FAIL rdy_hold_txn got %h exp %h", obs_arr[obs_rd], e); end
      obs_rd++;
    end
    tests_run++;
    if (gate_err !== ge0) begin tests_failed++; $display("FAIL rdy_gate got %0d exp %0d", gate_err, ge0); end
    repeat (3) @(posedge CLK);
    base = obs_n; rsp0 = rsp_cnt; bad = 1'b0;
    @(posedge CLK); #1;
    spur_rdy = 1'b1;
    repeat (3) begin
      @(posedge CLK); #3;
      if (bus.REQ_READY !== 1'b1 || bus.WE !== 1'b0 || bus.RREQ !== 1'b0) bad = 1'b1;
    end
    #1;
    spur_rdy = 1'b0;
    tests_run++;
    if (bad !== 1'b0 || rsp_cnt !== rsp0 || obs_n !== base) begin
      tests_failed++; $display("FAIL spurious_rdy got bad %b rsp %0d txns %0d exp 0 %0d 0", bad, rsp_cnt, obs_n - base, rsp0);
    end
    do_req(1'b1, 32'h80000030, 32'h0000005A, SZ_BYTE, 1'b0, cyc, rd, er, ra);
    tests_run++;
    if (cyc !== 5 || obs_n - base !== 1 || obs_arr[base] !== {1'b1, 32'h80000030, 8'h5A}) begin
      tests_failed++; $display("FAIL after_spurious got cyc %0d txns %0d txn %h exp 5 1 %h", cyc, obs_n - base, obs_arr[base], {1'b1, 32'h80000030, 8'h5A});
    end
  endtask

  task automatic test_reset_mid_transfer();
    int cyc; logic [31:0] rd; logic er, ra;
    logic found;
    int rsp0, base;
    rsp0 = rsp_cnt; found = 1'b0;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_ADDR = 32'h80000000;
    bus.REQ_WDATA = 32'h44332211; bus.REQ_SIZE = SZ_WORD; bus.REQ_UNSIGNED = 1'b0;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge CLK); #3;
      if (bus.WE && bus.ADDR == 32'h80000001) found = 1'b1;
    end
    tests_run++;
    if (found !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_reach got %b exp 1", found); end
    #1;
    RST = 1'b1;
    #1;
    tests_run++;
    if ({bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR, bus.WE, bus.RREQ} !== 5'b10000) begin
      tests_failed++; $display("FAIL rst_mid_flags got %b exp 10000", {bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR, bus.WE, bus.RREQ});
    end
    tests_run++;
    if (bus.ADDR !== 32'h0 || bus.BUS_DOUT !== 32'h0 || bus.RSP_RDATA !== 32'h0) begin
      tests_failed++; $display("FAIL rst_mid_bus got %h %h %h exp 0 0 0", bus.ADDR, bus.BUS_DOUT, bus.RSP_RDATA);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    tests_run++;
    if (rsp_cnt !== rsp0) begin tests_failed++; $display("FAIL rst_mid_no_rsp got %0d exp %0d", rsp_cnt, rsp0); end
    base = obs_n;
    do_req(1'b1, 32'h80000040, 32'h000000C7, SZ_BYTE, 1'b0, cyc, rd, er, ra);
    tests_run++;
    if (cyc !== 5 || er !== 1'b0 || obs_arr[base] !== {1'b1, 32'h80000040, 8'hC7}) begin
      tests_failed++; $display("FAIL rst_mid_recover got cyc %0d err %b txn %h exp 5 0 %h", cyc, er, obs_arr[base], {1'b1, 32'h80000040, 8'hC7});
    end
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; logic [31:0] rd; logic er, ra;
    ctl_en = 1'b0;
    do_req(1'b0, 32'h80000050, 32'h0, SZ_WORD, 1'b0, cyc, rd, er, ra);
    tests_run++;
    if (cyc !== TO + 1 || er !== 1'b1 || rd !== 32'h0) begin
      tests_failed++; $display("FAIL timeout_rsp got cyc %0d err %b rdata %h exp %0d 1 0", cyc, er, rd, TO + 1);
    end
    tests_run++;
    if (ra !== 1'b1 || bus.RREQ !== 1'b0) begin tests_failed++; $display("FAIL timeout_idle got ready %b rreq %b exp 1 0", ra, bus.RREQ); end
    ctl_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    logic bad;
    int rsp0;
    ctl_en = 1'b0; bad = 1'b0; rsp0 = rsp_cnt;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 32'h80000000;
    bus.REQ_SIZE = SZ_HALF; bus.REQ_UNSIGNED = 1'b0;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    repeat (1000) begin
      @(posedge CLK); #3;
      if (dbg_state !== ST_ISSUE || bus.RREQ !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0 || rsp_cnt !== rsp0) begin tests_failed++; $display("FAIL no_timeout got bad %b rsp %0d exp 0 %0d", bad, rsp_cnt, rsp0); end
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    ctl_en = 1'b1;
    @(posedge CLK); #3;
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL no_timeout_recover got %0d exp %0d", dbg_state, ST_IDLE); end
  endtask
`endif

  initial begin
    RST = 1'b1;
    spur_rdy = 1'b0; ctl_en = 1'b1; ctl_hold2 = 1'b0;
    bus.REQ_VALID = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 32'h0;
    bus.REQ_WDATA = 32'h0; bus.REQ_SIZE = SZ_BYTE; bus.REQ_UNSIGNED = 1'b0;
    for (int i = 0; i < 4; i++) rd_mem[i] = 8'h00;
    repeat (3) @(posedge CLK);
    test_reset();
    test_word_store();
    test_loads();
    test_errors();
    test_rdy_robustness();
    test_reset_mid_transfer();
`ifdef IO_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
